csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Control/status register file; the responder for the WB-stage CSR write, exception and ERTN interface.
//  Serves combinational CSR reads to WB. Applies masked CSR writes, exception entry and ERTN state changes.
//  Owns the timer, the 64-bit stable counter and interrupt aggregation. Sits beside the WB stage in myCPU.
// PARAMETERS
//  TID_RESET   32'h0  reset value of TID (0x40)
//  SAVE_NUM    4      number of SAVE scratch CSRs at 0x30..0x30+SAVE_NUM-1 (1..4)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  csr_raddr    in   9   read address
//  csr_rvalue   out  32  read data, combinational
//  csr_we       in   1   write enable (WB has already gated it with valid/no-exception)
//  csr_waddr    in   9   write address
//  csr_wmask    in   32  bit write mask
//  csr_wvalue   in   32  write data
//  wb_ex        in   1   exception commit
//  wb_ecode     in   6   exception code
//  wb_esubcode  in   9   exception subcode
//  wb_pc        in   32  PC of faulting instruction
//  wb_vaddr     in   32  faulting virtual address
//  ertn_flush   in   1   ERTN commit
//  hw_int_in    in   8   hardware interrupt lines (level)
//  ipi_int_in   in   1   inter-processor interrupt (level)
//  has_int      out  1   pending, enabled interrupt
//  ex_entry     out  32  {EENTRY.VA,6'b0}, exception target
//  ertn_era     out  32  ERA, ERTN target
//  crmd_plv     out  2   current privilege level
//  stable_cnt   out  64  stable counter value
// BEHAVIOUR
//  - Reset values: CRMD=32'h8 (DA=1, PLV=0, IE=0). PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVEn, TCFG and TICLR=0.
//    TVAL=32'hFFFF_FFFF; TID=TID_RESET; stable_cnt=0. Outputs follow these values.
//  - Read: csr_rvalue = selected CSR, same cycle. Unimplemented and reserved bits read 0.
//    TICLR reads 0. rdcntid (raddr 0x40) returns TID.
//  - Write: new = (old & ~wmask) | (wvalue & wmask), applied only to writable fields.
//    Writable fields: CRMD[4:0]; PRMD[2:0]; ECFG.LIE[9:0],[12:11]; ESTAT.IS[1:0]; ERA; BADV; EENTRY[31:6]; SAVEn; TID; TCFG.
//    A write takes effect on the next clock edge.
//  - Exception (wb_ex=1), one edge: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0.
//    Also: ERA<=wb_pc, ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode.
//    BADV<=wb_vaddr only when wb_ecode is 6'h08 (ADEF) or 6'h09 (ALE).
//  - ERTN (ertn_flush=1): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; all other CSRs are unchanged.
//  - Simultaneous events: wb_ex and ertn_flush are never both 1; if they are, wb_ex wins.
//    wb_ex beats csr_we for any field both touch.
//  - ESTAT.IS[9:2] <= hw_int_in and IS[12] <= ipi_int_in, sampled every cycle (1-cycle latency).
//  - has_int = CRMD.IE & |(ECFG.LIE[12:0] & ESTAT.IS[12:0]); combinational from registers.
//  - Stable counter: stable_cnt increments every cycle and wraps 2^64-1 -> 0.
//  - Timer: TCFG.En=bit0, Periodic=bit1, InitVal=[31:2].
//    A TCFG write loads TVAL<={wvalue[31:2],2'b00} on the same edge.
//    Otherwise, if En=1 and TVAL!=32'hFFFF_FFFF:
//      TVAL==0 & Periodic: TVAL reloads {InitVal,2'b00}.
//      TVAL==0 & !Periodic: TVAL becomes FFFF_FFFF and stops.
//      else: TVAL decrements by 1.
//  - Timer interrupt: IS[11] sets on the edge where En=1 and TVAL==0.
//    A TICLR write with wmask[0]&wvalue[0] clears IS[11]. If set and clear happen on the same edge, set wins.
//  - Reset asserted mid-operation overrides every event that cycle.
// CONFIGURATION
//  CSR_TIMER_EN defined: timer logic is present (TCFG/TVAL/TICLR, IS[11]).
//  CSR_TIMER_EN undefined: TCFG, TVAL and TICLR read 0; writes to them are dropped; IS[11] is tied to 0.
// TESTING
//  1. Reset -> read 0x0 gives 32'h8; read 0x42 gives 32'hFFFF_FFFF; read 0x40 gives TID_RESET; stable_cnt=0 then 1.
//  2. Write CRMD with wmask=0x4, wvalue=0x7 -> CRMD=32'hC (only IE bit changes).
//  3. CRMD.PLV=3, IE=1; wb_ex, ecode=0x09, pc=0x1C00_0100, vaddr=0x1234 ->
//     CRMD.PLV=0/IE=0, PRMD=0x7, ERA=0x1C00_0100, BADV=0x1234, ESTAT[21:16]=0x09.
//     Then ertn_flush -> CRMD.PLV=3, IE=1.
//  4. ECFG.LIE[11]=1, CRMD.IE=1; TCFG=0x0000_000B (init 8, periodic) ->
//     TVAL counts 8..0; IS[11]=1 and has_int=1 after 9 edges; TVAL reloads to 8.
//     TICLR wvalue=1 -> IS[11]=0.
//  5. hw_int_in=8'h01, LIE[2]=1, IE=1 -> has_int=1 one cycle later; with IE=0 -> has_int=0.
//  6. Same cycle: wb_ex=1 and csr_we to CRMD with wvalue=0x7 -> CRMD.IE=0, PLV=0 (exception wins).

Source files
------------

// File: rtl/csr_file.sv
// csr_file: control/status register file serving the WB stage.
//   Combinational CSR reads; masked CSR writes; exception entry and ERTN
//   state changes; timer, 64-bit stable counter and interrupt aggregation.
// Optional feature macro: CSR_TIMER_EN (timer TCFG/TVAL/TICLR and ESTAT.IS[11]).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   csr_raddr/csr_rvalue            read address / combinational read data
//   csr_we/csr_waddr/csr_wmask/csr_wvalue   masked write port
//   wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr  exception commit
//   ertn_flush                      ERTN commit
//   hw_int_in/ipi_int_in            level interrupt lines
//   has_int                         pending enabled interrupt
//   ex_entry/ertn_era/crmd_plv      exception target / ERTN target / privilege
//   stable_cnt                      64-bit free-running counter
module csr_file #(
  parameter logic [31:0] TID_RESET = 32'h0,
  parameter int unsigned SAVE_NUM  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  csr_raddr,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [8:0]  csr_waddr,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_era,
  output logic [1:0]  crmd_plv,
  output logic [63:0] stable_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 64;

  localparam logic [8:0] CSR_CRMD   = 9'h000;
  localparam logic [8:0] CSR_PRMD   = 9'h001;
  localparam logic [8:0] CSR_ECFG   = 9'h004;
  localparam logic [8:0] CSR_ESTAT  = 9'h005;
  localparam logic [8:0] CSR_ERA    = 9'h006;
  localparam logic [8:0] CSR_BADV   = 9'h007;
  localparam logic [8:0] CSR_EENTRY = 9'h00C;
  localparam logic [8:0] CSR_SAVE0  = 9'h030;
  localparam logic [8:0] CSR_TID    = 9'h040;
  localparam logic [8:0] CSR_TCFG   = 9'h041;
  localparam logic [8:0] CSR_TVAL   = 9'h042;

  // LIE bit 10 is reserved
  localparam logic [12:0] LIE_MASK = 13'h1BFF;

  logic [4:0]    crmd_r;      // {PG, DA, IE, PLV[1:0]}
  logic [2:0]    prmd_r;      // {PIE, PPLV[1:0]}
  logic [12:0]   ecfg_lie;
  logic [1:0]    is_sw;
  logic [7:0]    is_hw;
  logic          is_ipi;
  logic          timer_is;
  logic [5:0]    estat_ecode;
  logic [8:0]    estat_esub;
  logic [DW-1:0] era_r;
  logic [DW-1:0] badv_r;
  logic [25:0]   eentry_va;
  logic [DW-1:0] tid_r;
  logic [DW-1:0] tcfg_r;
  logic [DW-1:0] tval_r;
  logic [SW-1:0] stable_q;
  logic [DW-1:0] save_r [SAVE_NUM];

  logic [12:0] is_all;
  logic        badv_from_ex;

  assign is_all       = {is_ipi, timer_is, 1'b0, is_hw, is_sw};
  assign badv_from_ex = (wb_ecode == 6'h08) || (wb_ecode == 6'h09);

  // Architectural state; later assignments in this block take priority,
  // so exception/ERTN updates override a same-cycle CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_r      <= 5'h08;
      prmd_r      <= '0;
      ecfg_lie    <= '0;
      is_sw       <= '0;
      is_hw       <= '0;
      is_ipi      <= 1'b0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era_r       <= '0;
      badv_r      <= '0;
      eentry_va   <= '0;
      tid_r       <= TID_RESET;
      stable_q    <= '0;
      for (int i = 0; i < int'(SAVE_NUM); i++) save_r[i] <= '0;
    end else begin
      stable_q <= stable_q + 64'd1;
      is_hw    <= hw_int_in;
      is_ipi   <= ipi_int_in;
      if (csr_we) begin
        if (csr_waddr == CSR_CRMD)
          crmd_r <= (crmd_r & ~csr_wmask[4:0]) | (csr_wvalue[4:0] & csr_wmask[4:0]);
        if (csr_waddr == CSR_PRMD)
          prmd_r <= (prmd_r & ~csr_wmask[2:0]) | (csr_wvalue[2:0] & csr_wmask[2:0]);
        if (csr_waddr == CSR_ECFG)
          ecfg_lie <= ((ecfg_lie & ~csr_wmask[12:0]) | (csr_wvalue[12:0] & csr_wmask[12:0])) & LIE_MASK;
        if (csr_waddr == CSR_ESTAT)
          is_sw <= (is_sw & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        if (csr_waddr == CSR_ERA)
          era_r <= (era_r & ~csr_wmask) | (csr_wvalue & csr_wmask);
        if (csr_waddr == CSR_BADV)
          badv_r <= (badv_r & ~csr_wmask) | (csr_wvalue & csr_wmask);
        if (csr_waddr == CSR_EENTRY)
          eentry_va <= (eentry_va & ~csr_wmask[31:6]) | (csr_wvalue[31:6] & csr_wmask[31:6]);
        if (csr_waddr == CSR_TID)
          tid_r <= (tid_r & ~csr_wmask) | (csr_wvalue & csr_wmask);
        for (int i = 0; i < int'(SAVE_NUM); i++)
          if (csr_waddr == CSR_SAVE0 + 9'(i))
            save_r[i] <= (save_r[i] & ~csr_wmask) | (csr_wvalue & csr_wmask);
      end
      if (wb_ex) begin
        prmd_r      <= crmd_r[2:0];
        crmd_r[2:0] <= 3'b000;
        era_r       <= wb_pc;
        estat_ecode <= wb_ecode;
        estat_esub  <= wb_esubcode;
        if (badv_from_ex) badv_r <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd_r[2:0] <= prmd_r;
      end
    end
  end

`ifdef CSR_TIMER_EN
  localparam logic [8:0] CSR_TICLR = 9'h044;

  logic we_tcfg;
  logic ticlr_clr;
  logic timer_fire;

  assign we_tcfg    = csr_we & (csr_waddr == CSR_TCFG);
  assign ticlr_clr  = csr_we & (csr_waddr == CSR_TICLR) & csr_wmask[0] & csr_wvalue[0];
  assign timer_fire = tcfg_r[0] & (tval_r == '0);

  // Down-counter; all-ones is the idle value of a one-shot timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_r   <= '0;
      tval_r   <= '1;
      timer_is <= 1'b0;
    end else begin
      if (we_tcfg) begin
        tcfg_r <= (tcfg_r & ~csr_wmask) | (csr_wvalue & csr_wmask);
        tval_r <= {csr_wvalue[31:2], 2'b00};
      end else if (tcfg_r[0] && (tval_r != '1)) begin
        if (tval_r == '0)
          tval_r <= tcfg_r[1] ? {tcfg_r[31:2], 2'b00} : '1;
        else
          tval_r <= tval_r - 32'd1;
      end
      // set wins over a same-edge clear
      if (timer_fire)     timer_is <= 1'b1;
      else if (ticlr_clr) timer_is <= 1'b0;
    end
  end
`else
  assign tcfg_r   = '0;
  assign tval_r   = '0;
  assign timer_is = 1'b0;
`endif

  // Combinational read mux; unimplemented addresses and TICLR read 0.
  always_comb begin
    csr_rvalue = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rvalue = {27'b0, crmd_r};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_r};
      CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub, estat_ecode, 3'b000, is_all};
      CSR_ERA:    csr_rvalue = era_r;
      CSR_BADV:   csr_rvalue = badv_r;
      CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
      CSR_TID:    csr_rvalue = tid_r;
      CSR_TCFG:   csr_rvalue = tcfg_r;
      CSR_TVAL:   csr_rvalue = tval_r;
      default:    csr_rvalue = '0;
    endcase
    for (int i = 0; i < int'(SAVE_NUM); i++)
      if (csr_raddr == CSR_SAVE0 + 9'(i)) csr_rvalue = save_r[i];
  end

  assign has_int    = crmd_r[2] & (|(ecfg_lie & is_all));
  assign ex_entry   = {eentry_va, 6'b0};
  assign ertn_era   = era_r;
  assign crmd_plv   = crmd_r[1:0];
  assign stable_cnt = stable_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios followed by randomized traffic,
// checked against a word-level CSR model (address-indexed array plus
// per-address writable masks).
module tb_csr_file;

  localparam logic [31:0] TID_TB      = 32'hA5A5_0001;
  localparam int unsigned SAVE_NUM_TB = 3;
`ifdef CSR_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [8:0]  csr_raddr;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [8:0]  csr_waddr;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_era;
  logic [1:0]  crmd_plv;
  logic [63:0] stable_cnt;

  csr_file #(.TID_RESET(TID_TB), .SAVE_NUM(SAVE_NUM_TB)) dut (
    .clk(clk), .reset(reset),
    .csr_raddr(csr_raddr), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_era(ertn_era), .crmd_plv(crmd_plv), .stable_cnt(stable_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: one 32-bit word per CSR address, as software sees it.
  logic [31:0] m   [512];
  logic [31:0] m_n [512];
  logic [63:0] cnt, cnt_n;

  logic [8:0] addr_list [17] = '{9'h000, 9'h001, 9'h002, 9'h004, 9'h005, 9'h006, 9'h007,
                                 9'h00C, 9'h030, 9'h031, 9'h032, 9'h033, 9'h040, 9'h041,
                                 9'h042, 9'h044, 9'h100};

  function automatic logic [31:0] wr_mask(input logic [8:0] a);
    case (a)
      9'h000: return 32'h0000_001F;
      9'h001: return 32'h0000_0007;
      9'h004: return 32'h0000_1BFF;
      9'h005: return 32'h0000_0003;
      9'h006, 9'h007, 9'h040: return 32'hFFFF_FFFF;
      9'h00C: return 32'hFFFF_FFC0;
      9'h041: return TIMER ? 32'hFFFF_FFFF : 32'h0;
      default: return (a >= 9'h030 && a < 9'(9'h030 + SAVE_NUM_TB)) ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return m[0][2] & (|(m[4][12:0] & m[5][12:0]));
  endfunction

  // Next model state from the current inputs.
  task automatic model_step();
    logic [31:0] wm;
    logic fire, clr;
    m_n = m;
    if (reset) begin
      foreach (m_n[i]) m_n[i] = 32'h0;
      m_n[9'h000] = 32'h8;
      m_n[9'h040] = TID_TB;
      if (TIMER) m_n[9'h042] = 32'hFFFF_FFFF;
      cnt_n = 64'd0;
      return;
    end
    cnt_n = cnt + 64'd1;
    wm = csr_wmask & wr_mask(csr_waddr);
    if (csr_we) m_n[csr_waddr] = (m[csr_waddr] & ~wm) | (csr_wvalue & wm);
    fire = TIMER && m[9'h041][0] && (m[9'h042] == 32'h0);
    clr  = TIMER && csr_we && (csr_waddr == 9'h044) && csr_wmask[0] && csr_wvalue[0];
    if (TIMER) begin
      if (csr_we && csr_waddr == 9'h041)
        m_n[9'h042] = {csr_wvalue[31:2], 2'b00};
      else if (m[9'h041][0] && m[9'h042] != 32'hFFFF_FFFF) begin
        if (m[9'h042] == 32'h0)
          m_n[9'h042] = m[9'h041][1] ? {m[9'h041][31:2], 2'b00} : 32'hFFFF_FFFF;
        else
          m_n[9'h042] = m[9'h042] - 32'd1;
      end
    end
    m_n[5][9:2] = hw_int_in;
    m_n[5][12]  = ipi_int_in;
    if (fire) m_n[5][11] = 1'b1;
    else if (clr) m_n[5][11] = 1'b0;
    if (wb_ex) begin
      m_n[1][2:0]   = m[0][2:0];
      m_n[0][2:0]   = 3'b000;
      m_n[6]        = wb_pc;
      m_n[5][21:16] = wb_ecode;
      m_n[5][30:22] = wb_esubcode;
      if (wb_ecode == 6'h08 || wb_ecode == 6'h09) m_n[7] = wb_vaddr;
    end else if (ertn_flush) begin
      m_n[0][2:0] = m[1][2:0];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [8:0] a, output logic [31:0] v);
    csr_raddr = a;
    #1;
    v = csr_rvalue;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    m   = m_n;
    cnt = cnt_n;
    #1;
    csr_we     = 1'b0;
    wb_ex      = 1'b0;
    ertn_flush = 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] v;
    chk("has_int", 64'(has_int), 64'(m_has_int()));
    chk("ex_entry", 64'(ex_entry), 64'(m[9'h00C]));
    chk("ertn_era", 64'(ertn_era), 64'(m[9'h006]));
    chk("crmd_plv", 64'(crmd_plv), 64'(m[0][1:0]));
    chk("stable_cnt", stable_cnt, cnt);
    foreach (addr_list[i]) begin
      rd(addr_list[i], v);
      chk($sformatf("rd_%03h", addr_list[i]), 64'(v), 64'(m[addr_list[i]]));
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] msk, input logic [31:0] val);
    csr_we = 1'b1; csr_waddr = a; csr_wmask = msk; csr_wvalue = val;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; csr_raddr = '0; csr_we = 1'b0; csr_waddr = '0; csr_wmask = '0;
    csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
    wb_vaddr = '0; ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;

    // reset values
    cycle(); cycle();
    check_all();
    rd(9'h000, v); chk("reset_crmd", 64'(v), 64'h8);
    rd(9'h040, v); chk("reset_tid", 64'(v), 64'(TID_TB));
    rd(9'h042, v); chk("reset_tval", 64'(v), TIMER ? 64'hFFFF_FFFF : 64'h0);
    chk("reset_cnt", stable_cnt, 64'd0);
    reset = 1'b0;
    cycle();
    chk("cnt_one", stable_cnt, 64'd1);
    check_all();

    // masked write touches only IE
    wr(9'h000, 32'h4, 32'h7); cycle(); check_all();
    rd(9'h000, v); chk("crmd_masked", 64'(v), 64'hC);

    // exception entry then ERTN
    wr(9'h000, 32'h7, 32'h7); cycle(); check_all();
    wr(9'h00C, 32'hFFFF_FFFF, 32'h1C00_8ABC); cycle(); check_all();
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h1234;
    cycle(); check_all();
    chk("ex_plv", 64'(crmd_plv), 64'd0);
    rd(9'h000, v); chk("ex_ie", 64'(v[2]), 64'd0);
    rd(9'h001, v); chk("ex_prmd", 64'(v), 64'h7);
    rd(9'h006, v); chk("ex_era", 64'(v), 64'h1C00_0100);
    rd(9'h007, v); chk("ex_badv", 64'(v), 64'h1234);
    rd(9'h005, v); chk("ex_ecode", 64'(v[21:16]), 64'h09);
    chk("ex_entry_c", 64'(ex_entry), 64'h1C00_8A80);
    ertn_flush = 1'b1; cycle(); check_all();
    chk("ertn_plv", 64'(crmd_plv), 64'd3);
    rd(9'h000, v); chk("ertn_ie", 64'(v[2]), 64'd1);

    // timer: init 8, periodic
    wr(9'h004, 32'hFFFF_FFFF, 32'h800); cycle(); check_all();
    wr(9'h041, 32'hFFFF_FFFF, 32'hB); cycle(); check_all();
    if (TIMER) begin
      rd(9'h042, v); chk("tval_load", 64'(v), 64'd8);
      for (int k = 1; k <= 8; k++) begin
        cycle(); check_all();
        rd(9'h042, v); chk($sformatf("tval_k%0d", k), 64'(v), 64'(8 - k));
        rd(9'h005, v); chk("is11_low", 64'(v[11]), 64'd0);
      end
      cycle(); check_all();
      rd(9'h042, v); chk("tval_reload", 64'(v), 64'd8);
      rd(9'h005, v); chk("is11_set", 64'(v[11]), 64'd1);
      chk("timer_int", 64'(has_int), 64'd1);
      wr(9'h044, 32'h1, 32'h1); cycle(); check_all();
      rd(9'h005, v); chk("is11_clr", 64'(v[11]), 64'd0);
      rd(9'h044, v); chk("ticlr_rd0", 64'(v), 64'd0);
      wr(9'h041, 32'hFFFF_FFFF, 32'h0); cycle(); check_all();
    end else begin
      rd(9'h041, v); chk("tcfg_dropped", 64'(v), 64'd0);
      for (int k = 0; k < 9; k++) begin cycle(); check_all(); end
      rd(9'h005, v); chk("is11_tied", 64'(v[11]), 64'd0);
      chk("no_timer_int", 64'(has_int), 64'd0);
    end

    // hardware interrupt line
    wr(9'h004, 32'h4, 32'h4); cycle(); check_all();
    chk("hw_pre", 64'(has_int), 64'd0);
    hw_int_in = 8'h01; cycle(); check_all();
    chk("hw_int", 64'(has_int), 64'd1);
    wr(9'h000, 32'h4, 32'h0); cycle(); check_all();
    chk("hw_masked_ie", 64'(has_int), 64'd0);
    hw_int_in = 8'h00; cycle(); check_all();

    // exception beats a same-edge CRMD write
    wr(9'h000, 32'hFFFF_FFFF, 32'h7);
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0200; wb_vaddr = 32'hDEAD;
    cycle(); check_all();
    rd(9'h000, v); chk("exwin_crmd", 64'(v), 64'h0);
    rd(9'h001, v); chk("exwin_prmd", 64'(v), 64'h3);
    rd(9'h007, v); chk("exwin_badv", 64'(v), 64'h1234);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      reset      = ($urandom_range(0, 63) == 0);
      csr_we     = 1'($urandom_range(0, 1));
      csr_waddr  = addr_list[$urandom_range(0, 16)];
      csr_wmask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      csr_wvalue = (csr_waddr == 9'h041) ? 32'($urandom_range(0, 63)) : $urandom;
      r          = $urandom_range(0, 15);
      wb_ex      = (r == 0);
      ertn_flush = (r == 1);
      wb_ecode   = 6'($urandom_range(0, 12));
      wb_esubcode = 9'($urandom);
      wb_pc      = $urandom;
      wb_vaddr   = $urandom;
      hw_int_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ipi_int_in = ($urandom_range(0, 7) == 0);
      cycle();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
